// File: rtl/csr_exc_ctrl_if.sv
// WB / CSR / redirect bundle for csr_exc_ctrl.
// master = pipeline and CSR-file side, slave = the exception controller.
interface csr_exc_ctrl_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic        wb_ex_in;
  logic [5:0]  wb_ecode_in;
  logic [8:0]  wb_esubcode_in;
  logic [31:0] wb_vaddr_in;
  logic        wb_ertn;
  logic        csr_crmd_ie;
  logic [12:0] csr_ecfg_lie;
  logic [12:0] csr_estat_is;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_csr_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic        flush_valid;
  logic        flush_ready;
  logic [31:0] flush_pc;

  modport master (
    output wb_valid, wb_pc, wb_ex_in, wb_ecode_in, wb_esubcode_in, wb_vaddr_in, wb_ertn,
    output csr_crmd_ie, csr_ecfg_lie, csr_estat_is, ex_entry, ertn_entry, flush_ready,
    input  wb_ready, wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr, ertn_flush,
    input  flush_valid, flush_pc
  );

  modport slave (
    input  wb_valid, wb_pc, wb_ex_in, wb_ecode_in, wb_esubcode_in, wb_vaddr_in, wb_ertn,
    input  csr_crmd_ie, csr_ecfg_lie, csr_estat_is, ex_entry, ertn_entry, flush_ready,
    output wb_ready, wb_ex, wb_ecode, wb_esubcode, wb_csr_pc, wb_vaddr, ertn_flush,
    output flush_valid, flush_pc
  );
endinterface

// File: rtl/csr_exc_ctrl.sv
// Exception / interrupt / ertn commit sequencer: CSR strobe, then IF redirect, then drain.
// Optional event counters are enabled with `define CSR_EXC_CTRL_STATS_EN.
module csr_exc_ctrl #(
  parameter int         DRAIN_CYCLES = 2,
  parameter logic [5:0] INT_ECODE    = 6'h00
`ifdef CSR_EXC_CTRL_STATS_EN
  , parameter int       CNT_W        = 32
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  csr_exc_ctrl_if.slave     bus
`ifdef CSR_EXC_CTRL_STATS_EN
  , output logic [CNT_W-1:0] stat_exc_cnt
  , output logic [CNT_W-1:0] stat_int_cnt
  , output logic [CNT_W-1:0] stat_ertn_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, DRAIN} state_e;
  typedef enum logic [1:0] {KIND_EXC, KIND_INT, KIND_ERTN} kind_e;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e         state_q, state_d;
  kind_e          evKind_q;
  logic [31:0]    evPc_q;
  logic [5:0]     evEcode_q;
  logic [8:0]     evEsub_q;
  logic [31:0]    evVaddr_q;
  logic [31:0]    flushPc_q;
  logic [DCW-1:0] drainCnt_q;

  logic intPend;
  logic evTake;

  assign intPend = bus.csr_crmd_ie & (|(bus.csr_ecfg_lie & bus.csr_estat_is));
  assign evTake  = bus.wb_valid & (intPend | bus.wb_ex_in | bus.wb_ertn);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (evTake) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (bus.flush_ready) state_d = DRAIN;
      DRAIN:    if (drainCnt_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Interrupts win over the WB instruction, which is then not retired.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      evKind_q   <= KIND_EXC;
      evPc_q     <= '0;
      evEcode_q  <= '0;
      evEsub_q   <= '0;
      evVaddr_q  <= '0;
      flushPc_q  <= '0;
      drainCnt_q <= '0;
    end else begin
      if (state_q == IDLE && evTake) begin
        evPc_q <= bus.wb_pc;
        if (intPend) begin
          evKind_q  <= KIND_INT;
          evEcode_q <= INT_ECODE;
          evEsub_q  <= '0;
          evVaddr_q <= '0;
        end else begin
          evKind_q  <= bus.wb_ex_in ? KIND_EXC : KIND_ERTN;
          evEcode_q <= bus.wb_ecode_in;
          evEsub_q  <= bus.wb_esubcode_in;
          evVaddr_q <= bus.wb_vaddr_in;
        end
      end
      if (state_q == COMMIT)
        flushPc_q <= (evKind_q == KIND_ERTN) ? bus.ertn_entry : bus.ex_entry;
      if (state_q == REDIRECT && bus.flush_ready)
        drainCnt_q <= DCW'(DRAIN_CYCLES - 1);
      else if (state_q == DRAIN && drainCnt_q != '0)
        drainCnt_q <= drainCnt_q - 1'b1;
    end
  end

  always_comb begin
    bus.wb_ready    = 1'b0;
    bus.wb_ex       = 1'b0;
    bus.wb_ecode    = '0;
    bus.wb_esubcode = '0;
    bus.wb_csr_pc   = '0;
    bus.wb_vaddr    = '0;
    bus.ertn_flush  = 1'b0;
    bus.flush_valid = 1'b0;
    case (state_q)
      IDLE: bus.wb_ready = 1'b1;
      COMMIT: begin
        if (evKind_q == KIND_ERTN) begin
          bus.ertn_flush = 1'b1;
        end else begin
          bus.wb_ex       = 1'b1;
          bus.wb_ecode    = evEcode_q;
          bus.wb_esubcode = evEsub_q;
          bus.wb_csr_pc   = evPc_q;
          bus.wb_vaddr    = evVaddr_q;
        end
      end
      REDIRECT: bus.flush_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.flush_pc = flushPc_q;

`ifdef CSR_EXC_CTRL_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_exc_cnt  <= '0;
      stat_int_cnt  <= '0;
      stat_ertn_cnt <= '0;
    end else if (state_q == COMMIT) begin
      case (evKind_q)
        KIND_EXC:  stat_exc_cnt  <= stat_exc_cnt + 1'b1;
        KIND_INT:  stat_int_cnt  <= stat_int_cnt + 1'b1;
        KIND_ERTN: stat_ertn_cnt <= stat_ertn_cnt + 1'b1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_csr_exc_ctrl.sv
// Randomized bench for csr_exc_ctrl against a transaction-level model of the event rules.
module tb_csr_exc_ctrl;

  localparam int         DRAIN  = 3;
  localparam logic [5:0] INT_EC = 6'h00;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  csr_exc_ctrl_if bus ();

`ifdef CSR_EXC_CTRL_STATS_EN
  logic [31:0] statExc, statInt, statErtn;
`endif

  csr_exc_ctrl #(.DRAIN_CYCLES(DRAIN), .INT_ECODE(INT_EC)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
`ifdef CSR_EXC_CTRL_STATS_EN
    , .stat_exc_cnt  (statExc)
    , .stat_int_cnt  (statInt)
    , .stat_ertn_cnt (statErtn)
`endif
  );

  typedef struct {
    bit          v;
    bit          ie;
    logic [12:0] lie;
    logic [12:0] is;
    bit          ex;
    logic [5:0]  ec;
    logic [8:0]  esc;
    logic [31:0] pc;
    logic [31:0] va;
    bit          ertn;
    logic [31:0] exEnt;
    logic [31:0] erEnt;
    int          stall;
  } evt_t;

  int total = 0;
  int bad   = 0;
  int mExc  = 0;
  int mInt  = 0;
  int mErtn = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearWb();
    bus.wb_valid       = 1'b0;
    bus.wb_ex_in       = 1'b0;
    bus.wb_ertn        = 1'b0;
    bus.wb_pc          = '0;
    bus.wb_ecode_in    = '0;
    bus.wb_esubcode_in = '0;
    bus.wb_vaddr_in    = '0;
    bus.csr_crmd_ie    = 1'b0;
    bus.csr_ecfg_lie   = '0;
    bus.csr_estat_is   = '0;
  endtask

  task automatic checkStats();
`ifdef CSR_EXC_CTRL_STATS_EN
    checkOutput("stat_exc", statExc, 32'(mExc));
    checkOutput("stat_int", statInt, 32'(mInt));
    checkOutput("stat_ertn", statErtn, 32'(mErtn));
`endif
  endtask

  // Drives one WB cycle from IDLE and follows the whole commit/redirect/drain sequence.
  task automatic applyStimulus(input evt_t e);
    bit          intp, taken, isErtn;
    logic [5:0]  expEc;
    logic [8:0]  expEsc;
    logic [31:0] expVa, expFlush;
    checkOutput("idle_ready", 32'(bus.wb_ready), 32'd1);
    bus.wb_valid       = e.v;
    bus.csr_crmd_ie    = e.ie;
    bus.csr_ecfg_lie   = e.lie;
    bus.csr_estat_is   = e.is;
    bus.wb_ex_in       = e.ex;
    bus.wb_ecode_in    = e.ec;
    bus.wb_esubcode_in = e.esc;
    bus.wb_pc          = e.pc;
    bus.wb_vaddr_in    = e.va;
    bus.wb_ertn        = e.ertn;
    bus.ex_entry       = e.exEnt;
    bus.ertn_entry     = e.erEnt;
    bus.flush_ready    = 1'($urandom);
    intp  = e.ie && ((e.lie & e.is) != 13'd0);
    taken = e.v && (intp || e.ex || e.ertn);
    tick();
    if (!taken) begin
      checkOutput("noev_wbex", 32'(bus.wb_ex), 32'd0);
      checkOutput("noev_ertn", 32'(bus.ertn_flush), 32'd0);
      checkOutput("noev_ready", 32'(bus.wb_ready), 32'd1);
      clearWb();
      return;
    end
    isErtn = 1'b0;
    if (intp) begin
      expEc = INT_EC; expEsc = '0; expVa = '0; mInt++;
    end else if (e.ex) begin
      expEc = e.ec; expEsc = e.esc; expVa = e.va; mExc++;
    end else begin
      expEc = '0; expEsc = '0; expVa = '0; isErtn = 1'b1; mErtn++;
    end
    expFlush = isErtn ? e.erEnt : e.exEnt;
    bus.wb_valid    = 1'($urandom);
    bus.wb_ex_in    = 1'($urandom);
    bus.wb_ertn     = 1'($urandom);
    bus.wb_pc       = $urandom;
    bus.flush_ready = 1'($urandom);
    checkOutput("commit_wbex", 32'(bus.wb_ex), 32'(!isErtn));
    checkOutput("commit_ertn", 32'(bus.ertn_flush), 32'(isErtn));
    checkOutput("commit_ready", 32'(bus.wb_ready), 32'd0);
    checkOutput("commit_fv", 32'(bus.flush_valid), 32'd0);
    if (!isErtn) begin
      checkOutput("commit_ecode", 32'(bus.wb_ecode), 32'(expEc));
      checkOutput("commit_esub", 32'(bus.wb_esubcode), 32'(expEsc));
      checkOutput("commit_pc", bus.wb_csr_pc, e.pc);
      checkOutput("commit_vaddr", bus.wb_vaddr, expVa);
    end
    for (int k = 0; k <= e.stall; k++) begin
      tick();
      checkOutput("redir_fv", 32'(bus.flush_valid), 32'd1);
      checkOutput("redir_pc", bus.flush_pc, expFlush);
      checkOutput("redir_strobe", 32'(bus.wb_ex | bus.ertn_flush), 32'd0);
      checkOutput("redir_ready", 32'(bus.wb_ready), 32'd0);
      bus.flush_ready = (k == e.stall);
    end
    clearWb();
    for (int d = 0; d < DRAIN; d++) begin
      tick();
      bus.flush_ready = 1'($urandom);
      checkOutput("drain_fv", 32'(bus.flush_valid), 32'd0);
      checkOutput("drain_ready", 32'(bus.wb_ready), 32'd0);
    end
    tick();
    bus.flush_ready = 1'b0;
    checkOutput("done_ready", 32'(bus.wb_ready), 32'd1);
    checkOutput("done_fv", 32'(bus.flush_valid), 32'd0);
  endtask

  function automatic evt_t blankEvt();
    evt_t e;
    e.v = 1'b1; e.ie = 1'b0; e.lie = '0; e.is = '0; e.ex = 1'b0; e.ec = '0; e.esc = '0;
    e.pc = '0; e.va = '0; e.ertn = 1'b0; e.exEnt = '0; e.erEnt = '0; e.stall = 0;
    return e;
  endfunction

  initial begin
    evt_t e;
    resetn = 1'b0;
    clearWb();
    bus.ex_entry    = '0;
    bus.ertn_entry  = '0;
    bus.flush_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(bus.wb_ready), 32'd1);
    checkOutput("rst_fv", 32'(bus.flush_valid), 32'd0);
    checkOutput("rst_wbex", 32'(bus.wb_ex), 32'd0);
    checkOutput("rst_ertn", 32'(bus.ertn_flush), 32'd0);
    checkOutput("rst_fpc", bus.flush_pc, 32'd0);
    checkStats();
    @(negedge clk);
    resetn = 1'b1;
    tick();

    $display("[TB] syscall exception");
    e = blankEvt(); e.ex = 1'b1; e.ec = 6'h0B; e.pc = 32'h1C000100; e.exEnt = 32'h1C008000;
    applyStimulus(e);

    $display("[TB] interrupt beats exception");
    e = blankEvt(); e.ie = 1'b1; e.lie = 13'h004; e.is = 13'h004; e.ex = 1'b1; e.ec = 6'h0B;
    e.esc = 9'h005; e.va = 32'h1234; e.pc = 32'h1C000200; e.exEnt = 32'h1C008000;
    applyStimulus(e);

    $display("[TB] masked interrupt");
    e = blankEvt(); e.lie = 13'h1FFF; e.is = 13'h1FFF;
    applyStimulus(e);
    applyStimulus(e);

    $display("[TB] pending interrupt without wb_valid");
    e = blankEvt(); e.v = 1'b0; e.ie = 1'b1; e.lie = 13'h001; e.is = 13'h001;
    applyStimulus(e);

    $display("[TB] ertn");
    e = blankEvt(); e.ertn = 1'b1; e.erEnt = 32'h1C000204; e.exEnt = 32'h1C008000;
    applyStimulus(e);

    $display("[TB] exception beats ertn, 5-cycle backpressure");
    e = blankEvt(); e.ex = 1'b1; e.ertn = 1'b1; e.ec = 6'h03; e.pc = 32'h1C000300;
    e.exEnt = 32'h1C00A000; e.erEnt = 32'h1C000204; e.stall = 5;
    applyStimulus(e);

    $display("[TB] reset in REDIRECT");
    bus.wb_valid = 1'b1; bus.wb_ex_in = 1'b1; bus.wb_ecode_in = 6'h0B; bus.ex_entry = 32'h1C008000;
    bus.flush_ready = 1'b0;
    tick();
    clearWb();
    tick();
    tick();
    checkOutput("pre_rst_fv", 32'(bus.flush_valid), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst_fv", 32'(bus.flush_valid), 32'd0);
    checkOutput("arst_ready", 32'(bus.wb_ready), 32'd1);
    mExc = 0; mInt = 0; mErtn = 0;
    checkStats();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    checkOutput("post_rst_ready", 32'(bus.wb_ready), 32'd1);

    $display("[TB] random events");
    for (int n = 0; n < 300; n++) begin
      e = blankEvt();
      e.v     = ($urandom % 8) != 0;
      e.ie    = 1'($urandom);
      e.lie   = 13'($urandom & $urandom & $urandom);
      e.is    = 13'($urandom & $urandom);
      e.ex    = ($urandom % 3) == 0;
      e.ertn  = ($urandom % 3) == 0;
      e.ec    = 6'($urandom);
      e.esc   = 9'($urandom);
      e.pc    = $urandom;
      e.va    = $urandom;
      e.exEnt = $urandom;
      e.erEnt = $urandom;
      e.stall = int'($urandom % 4);
      applyStimulus(e);
    end
    checkStats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
